// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizing for the multi-read-port register file.
package regfile_pkg;

  // Clear sequencer states: IDLE waits for clear_i, SWEEP zeroes one register per cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clearState_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_NUM_READ   = 2;

endpackage

// File: rtl/regfile_if.sv
// regfile_if: decode/writeback bus of the register file.
// The master side (pipeline) drives addresses and write data; the slave side
// (regfile_mp) returns read data, busy and write acknowledge.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ
);

  logic                           wen_i;
  logic [ADDR_WIDTH-1:0]          regWrite_i;
  logic [DATA_WIDTH-1:0]          dataWrite_i;
  logic [NUM_READ*ADDR_WIDTH-1:0] regRead_i;
  logic [NUM_READ*DATA_WIDTH-1:0] dataRead_o;
  logic                           clear_i;
  logic                           busy_o;
  logic                           wack_o;

  modport master (
    output wen_i, regWrite_i, dataWrite_i, regRead_i, clear_i,
    input  dataRead_o, busy_o, wack_o
  );

  modport slave (
    input  wen_i, regWrite_i, dataWrite_i, regRead_i, clear_i,
    output dataRead_o, busy_o, wack_o
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sweeps every register address once, one per cycle,
// after clear_i is seen in IDLE. busy_o is high for exactly DEPTH cycles.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  sweepWe,
  output logic [ADDR_WIDTH-1:0] sweepAddr
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  clearState_e           state;
  clearState_e           stateNext;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptrNext;

  // State and pointer registers; reset abandons any sweep in progress.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
    end
  end

  // Next state: start on clear_i, walk the pointer, leave after the last address.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    case (state)
      IDLE: begin
        if (clear_i) begin
          stateNext = SWEEP;
          ptrNext   = '0;
        end
      end
      SWEEP: begin
        ptrNext = ptr + PTR_ONE;
        if (ptr == PTR_LAST) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        ptrNext   = '0;
      end
    endcase
  end

  assign busy_o    = (state == SWEEP);
  assign sweepWe   = (state == SWEEP);
  assign sweepAddr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: one synchronous write port, NUM_READ combinational read ports with
// write-to-read bypass, and a clear sweep that zeroes the array without reset.
// Optional build macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = DEFAULT_NUM_READ
) (
  input logic      clk,
  input logic      rst_n_i,
  regfile_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]          regArray [DEPTH];
  logic [NUM_READ*DATA_WIDTH-1:0] readFlat;
  logic [ADDR_WIDTH-1:0]          sweepAddr;
  logic                           sweepWe;
  logic                           busy;
  logic                           writeAllowed;
  logic                           wrAccept;
  logic                           wackReg;

`ifdef REGFILE_ZERO_REG_EN
  assign writeAllowed = (bus.regWrite_i != '0);
`else
  assign writeAllowed = 1'b1;
`endif

  // Writes are dropped while the sweep owns the array.
  assign wrAccept = bus.wen_i && !busy && writeAllowed;

  regfile_clear_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uClearFsm (
    .clk      (clk),
    .rst_n_i  (rst_n_i),
    .clear_i  (bus.clear_i),
    .busy_o   (busy),
    .sweepWe  (sweepWe),
    .sweepAddr(sweepAddr)
  );

  // Storage: sweep zeroing and pipeline writes never coincide (writes need !busy).
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regArray[i] <= '0;
      end
    end else begin
      if (sweepWe) begin
        regArray[sweepAddr] <= '0;
      end
      if (wrAccept) begin
        regArray[bus.regWrite_i] <= bus.dataWrite_i;
      end
    end
  end

  // Write acknowledge: one-cycle pulse after each accepted write.
  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      wackReg <= 1'b0;
    end else begin
      wackReg <= wrAccept;
    end
  end

  // Per-port read mux: hardwired zero, then same-cycle bypass, then stored value.
  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : gReadPort
      logic [ADDR_WIDTH-1:0] rdAddr;
      logic                  bypass;
      logic                  forceZero;

      assign rdAddr = bus.regRead_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign bypass = wrAccept && (bus.regWrite_i == rdAddr);
`ifdef REGFILE_ZERO_REG_EN
      assign forceZero = (rdAddr == '0);
`else
      assign forceZero = 1'b0;
`endif
      assign readFlat[gi*DATA_WIDTH +: DATA_WIDTH] =
        forceZero ? '0 : (bypass ? bus.dataWrite_i : regArray[rdAddr]);
    end
  endgenerate

  assign bus.dataRead_o = readFlat;
  assign bus.busy_o     = busy;
  assign bus.wack_o     = wackReg;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus for regfile_mp with a behavioural array model
// compared every cycle, plus hand-computed literal expectations.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int NR    = 2;
  localparam int DEPTH = 8;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk = ~clk;

  regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
    .clk    (clk),
    .rst_n_i(rst_n_i),
    .bus    (bus.slave)
  );

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 1'b0;

  // Behavioural model: array contents, remaining sweep cycles, expected ack.
  logic [DW-1:0] model [DEPTH];
  int            clearLeft = 0;
  logic          wackExp = 1'b0;
  logic          accept;

  assign accept = bus.wen_i && (clearLeft == 0) && !(ZERO_EN && bus.regWrite_i == '0);

  function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
    if (ZERO_EN && a == '0) return '0;
    if (accept && bus.regWrite_i == a) return bus.dataWrite_i;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Model update at each clock edge.
  always @(posedge clk) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) model[i] <= '0;
      clearLeft <= 0;
      wackExp   <= 1'b0;
    end else begin
      wackExp <= accept;
      if (clearLeft > 0) begin
        model[DEPTH - clearLeft] <= '0;
        clearLeft <= clearLeft - 1;
      end else if (bus.clear_i) begin
        clearLeft <= DEPTH;
      end
      if (accept) model[bus.regWrite_i] <= bus.dataWrite_i;
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      check("model_busy", {7'd0, bus.busy_o}, {7'd0, (clearLeft > 0)});
      check("model_wack", {7'd0, bus.wack_o}, {7'd0, wackExp});
      for (int k = 0; k < NR; k++) begin
        check($sformatf("model_read%0d", k), bus.dataRead_o[k*DW +: DW],
              expRead(bus.regRead_i[k*AW +: AW]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic clr);
    bus.wen_i       = w;
    bus.regWrite_i  = wa;
    bus.dataWrite_i = wd;
    bus.clear_i     = clr;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.regRead_i = {a1, a0};
  endtask

  function automatic logic [DW-1:0] port(input int k);
    return bus.dataRead_o[k*DW +: DW];
  endfunction

  int busyCycles;

  initial begin
    drive(1'b0, '0, '0, 1'b0);
    rd('0, '0);
    rst_n_i = 1'b0;
    cyc();
    cyc();
    rst_n_i = 1'b1;
    checkEn = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", {7'd0, bus.busy_o}, 8'h00);
    check("rst_wack", {7'd0, bus.wack_o}, 8'h00);
    check("rst_r0", port(0), 8'h00);

    // Write r3/r5, bypass and ack
    cyc(); drive(1'b1, 3'd3, 8'hCC, 1'b0); rd(3'd3, 3'd5);
    @(negedge clk);
    check("byp_r3", port(0), 8'hCC);
    check("r5_before", port(1), 8'h00);
    cyc(); drive(1'b1, 3'd5, 8'h55, 1'b0);
    @(negedge clk);
    check("wack_r3", {7'd0, bus.wack_o}, 8'h01);
    check("byp_r5", port(1), 8'h55);
    cyc(); drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("read_r3", port(0), 8'hCC);
    check("read_r5", port(1), 8'h55);
    check("wack_r5", {7'd0, bus.wack_o}, 8'h01);
    cyc();
    @(negedge clk);
    check("wack_drop", {7'd0, bus.wack_o}, 8'h00);

    // Bypass on port 0 only
    cyc(); drive(1'b1, 3'd2, 8'hFF, 1'b0); rd(3'd2, 3'd1);
    @(negedge clk);
    check("byp_r2", port(0), 8'hFF);
    check("r1_unaff", port(1), 8'h00);

    // Fill, clear, dropped write mid-sweep
    for (int i = 0; i < DEPTH; i++) begin
      cyc(); drive(1'b1, AW'(i), DW'(8'h10 + i), 1'b0);
    end
    cyc(); drive(1'b0, '0, '0, 1'b1); rd(3'd4, 3'd0);
    cyc(); drive(1'b0, '0, '0, 1'b0);
    busyCycles = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) drive(1'b1, 3'd4, 8'hAA, 1'b0);
      else drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      if (bus.busy_o) busyCycles++;
      if (c == 3) check("sweep_nobyp", port(0), 8'h14);
      if (c == 4) check("sweep_nowack", {7'd0, bus.wack_o}, 8'h00);
      cyc();
    end
    check("busy_len", DW'(busyCycles), 8'd8);
    for (int a = 0; a < 4; a++) begin
      rd(AW'(a), AW'(a + 4));
      @(negedge clk);
      check($sformatf("swept_r%0d", a), port(0), 8'h00);
      check($sformatf("swept_r%0d", a + 4), port(1), 8'h00);
      cyc();
    end

    // Clear and write in the same cycle
    drive(1'b1, 3'd6, 8'h12, 1'b1); rd(3'd6, 3'd6);
    @(negedge clk);
    check("clrw_byp", port(0), 8'h12);
    cyc(); drive(1'b0, '0, '0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) check("clrw_wack", {7'd0, bus.wack_o}, 8'h01);
      if (c == 6) check("clrw_kept", port(0), 8'h12);
      if (c == 7) check("clrw_swept", port(0), 8'h00);
      cyc();
    end
    @(negedge clk);
    check("clrw_idle", {7'd0, bus.busy_o}, 8'h00);

    // Reset mid-sweep
    cyc(); drive(1'b1, 3'd7, 8'h33, 1'b0);
    cyc(); drive(1'b0, '0, '0, 1'b1); rd(3'd7, 3'd0);
    cyc(); drive(1'b0, '0, '0, 1'b0);
    cyc(); cyc(); cyc();
    rst_n_i = 1'b0;
    cyc();
    rst_n_i = 1'b1;
    @(negedge clk);
    check("abort_busy", {7'd0, bus.busy_o}, 8'h00);
    check("abort_r7", port(0), 8'h00);
    cyc(); drive(1'b0, '0, '0, 1'b1);
    cyc(); drive(1'b0, '0, '0, 1'b0);
    busyCycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.busy_o) busyCycles++;
      cyc();
    end
    check("busy_len2", DW'(busyCycles), 8'd8);

    // Register 0 behaviour
    drive(1'b1, 3'd0, 8'h77, 1'b0); rd(3'd0, 3'd0);
    @(negedge clk);
    check("r0_byp", port(0), ZERO_EN ? 8'h00 : 8'h77);
    cyc(); drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check("r0_wack", {7'd0, bus.wack_o}, ZERO_EN ? 8'h00 : 8'h01);
    check("r0_read", port(0), ZERO_EN ? 8'h00 : 8'h77);
    cyc();

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
